// File: rtl/arb2_pkg.sv
// arb2_pkg: shared types and helpers for the two-requester mux arbiter.
//   state_t        - arbiter FSM states (idle, requester 0 owns, requester 1 owns)
//   beat_cnt_width - width of the per-packet beat counter for a given MAX_BEATS
package arb2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  // The counter only has to reach MAX_BEATS-1; the floor of 1 bit keeps the
  // vector legal for degenerate parameter values.
  function automatic int beat_cnt_width(input int max_beats);
    return (max_beats > 1) ? $clog2(max_beats) : 1;
  endfunction

endpackage

// File: rtl/mux2_w.sv
// mux2_w: WIDTH-bit 2:1 multiplexer.
//   out - selected data (in0 when S=0, in1 when S=1)
//   in0 - data input 0
//   in1 - data input 1
//   S   - select
module mux2_w #(
  parameter int WIDTH = 8
) (
  output logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             S
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign out[gi] = S ? in1[gi] : in0[gi];
    end
  endgenerate

endmodule

// File: rtl/arb2_mux_ctrl.sv
// arb2_mux_ctrl: round-robin arbiter that shares one 2:1 mux datapath between
// two packet requesters. A grant lasts a whole packet; priority flips after
// every packet; packets longer than MAX_BEATS are cut at MAX_BEATS beats.
//   clk, rst                       - clock, synchronous active-high reset
//   in0_valid/ready/data/last      - requester 0 stream
//   in1_valid/ready/data/last      - requester 1 stream
//   out_valid/ready/data/last      - shared output stream
//   sel                            - current or most recent owner (mux select)
//   busy                           - a packet is currently owned
//   trunc_err                      - sticky flag, a packet was truncated
module arb2_mux_ctrl
  import arb2_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_last,
  input  logic             in1_valid,
  output logic             in1_ready,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             sel,
  output logic             busy,
  output logic             trunc_err
);

  localparam int CNT_W = beat_cnt_width(MAX_BEATS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_BEATS - 1);

  state_t           state_reg, state_next;
  logic             sel_reg, sel_next;
  logic             prio_reg, prio_next;
  logic [CNT_W-1:0] beat_cnt_reg, beat_cnt_next;
  logic             trunc_err_reg, trunc_err_next;

  logic             at_limit;
  logic             own_valid;
  logic             own_last;
  logic             valid_raw;
  logic             ready0_raw;
  logic             ready1_raw;
  logic             last_comb;

  assign at_limit = (beat_cnt_reg == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      sel_reg       <= 1'b0;
      prio_reg      <= 1'b0;
      beat_cnt_reg  <= '0;
      trunc_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      sel_reg       <= sel_next;
      prio_reg      <= prio_next;
      beat_cnt_reg  <= beat_cnt_next;
      trunc_err_reg <= trunc_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    sel_next       = sel_reg;
    prio_next      = prio_reg;
    beat_cnt_next  = beat_cnt_reg;
    trunc_err_next = trunc_err_reg;
    own_valid      = 1'b0;
    own_last       = 1'b0;
    valid_raw      = 1'b0;
    ready0_raw     = 1'b0;
    ready1_raw     = 1'b0;
    last_comb      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (in0_valid && in1_valid) begin
          state_next = prio_reg ? OWN1 : OWN0;
          sel_next   = prio_reg;
        end else if (in0_valid) begin
          state_next = OWN0;
          sel_next   = 1'b0;
        end else if (in1_valid) begin
          state_next = OWN1;
          sel_next   = 1'b1;
        end
      end
      OWN0: begin
        own_valid  = in0_valid;
        own_last   = in0_last;
        ready0_raw = out_ready;
      end
      OWN1: begin
        own_valid  = in1_valid;
        own_last   = in1_last;
        ready1_raw = out_ready;
      end
      default: state_next = IDLE;
    endcase

    if (state_reg == OWN0 || state_reg == OWN1) begin
      valid_raw = own_valid;
      // The limit forces a packet end even if the owner never raises last.
      last_comb = own_last | at_limit;
      if (own_valid && out_ready) begin
        if (last_comb) begin
          state_next    = IDLE;
          // Hand priority to the other requester for the next packet.
          prio_next     = (state_reg == OWN0);
          beat_cnt_next = '0;
          if (at_limit && !own_last) begin
            trunc_err_next = 1'b1;
          end
        end else begin
          beat_cnt_next = beat_cnt_reg + 1'b1;
        end
      end
    end
  end

  // Handshakes are blanked during reset so nothing moves in a reset cycle.
  assign out_valid = valid_raw  & ~rst;
  assign in0_ready = ready0_raw & ~rst;
  assign in1_ready = ready1_raw & ~rst;
  assign out_last  = last_comb;
  assign sel       = sel_reg;
  assign busy      = (state_reg != IDLE);
  assign trunc_err = trunc_err_reg;

  mux2_w #(
    .WIDTH(WIDTH)
  ) u_data_mux (
    .out(out_data),
    .in0(in0_data),
    .in1(in1_data),
    .S  (sel_reg)
  );

endmodule
